// File: rtl/phy_rx_sync_ctrl.sv
// rtl/phy_rx_sync_ctrl.sv - PHY RX comma-based link synchronization controller
//
// Purpose: acquires byte lock by counting consecutive 8'hBC commas, forwards
// non-comma bytes as data while locked, requests deserializer bit slips while
// searching, and drops lock after a long run of non-comma bytes.
//
// Ports:
//   clk_4f      byte clock, all state on the rising edge
//   rst_L       asynchronous active-low reset
//   sync_en     acquisition enable; low forces SEARCH
//   sp_in       deserialized byte, valid every cycle
//   data_out    registered forwarded data byte
//   valid_out   registered data-valid qualifier for data_out
//   active      link locked (state == ACTIVE)
//   bit_slip    registered one-cycle slip request
//   sync_state  SEARCH=0, CHECK=1, ACTIVE=2
//   lol_cnt     saturating loss-of-lock count
//
// Build option: define SYNC_LOL_CNT_EN to build the loss-of-lock counter;
// otherwise lol_cnt is tied to zero.

module phy_rx_sync_ctrl #(
    parameter int LOCK_COUNT = 4,
    parameter int SLIP_WAIT  = 16,
    parameter int LOS_LIMIT  = 64
) (
    input  logic       clk_4f,
    input  logic       rst_L,
    input  logic       sync_en,
    input  logic [7:0] sp_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       bit_slip,
    output logic [1:0] sync_state,
    output logic [7:0] lol_cnt
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [7:0] COMMA     = 8'hBC;
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [7:0] SLIP_LAST = 8'(SLIP_WAIT - 1);
    localparam logic [7:0] LOS_LAST  = 8'(LOS_LIMIT - 1);

    state_t     state_q, state_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] los_cnt_q, los_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       slip_q, slip_d;
    logic       lol_inc;
    logic       is_comma;

    assign is_comma = (sp_in == COMMA);

    always_comb begin
        state_d    = state_q;
        bc_cnt_d   = bc_cnt_q;
        wait_cnt_d = wait_cnt_q;
        los_cnt_d  = los_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        slip_d     = 1'b0;
        lol_inc    = 1'b0;

        if (!sync_en) begin
            state_d    = SEARCH;
            bc_cnt_d   = 4'd0;
            wait_cnt_d = 8'd0;
            los_cnt_d  = 8'd0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (is_comma) begin
                        // A comma in the slip cycle wins: no slip is issued.
                        wait_cnt_d = 8'd0;
                        if (LOCK_COUNT == 1) begin
                            state_d   = ACTIVE;
                            bc_cnt_d  = 4'd0;
                            los_cnt_d = 8'd0;
                        end else begin
                            state_d  = CHECK;
                            bc_cnt_d = 4'd1;
                        end
                    end else if (wait_cnt_q == SLIP_LAST) begin
                        slip_d     = 1'b1;
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                CHECK: begin
                    if (is_comma) begin
                        if (bc_cnt_q == LOCK_LAST) begin
                            state_d   = ACTIVE;
                            bc_cnt_d  = 4'd0;
                            los_cnt_d = 8'd0;
                        end else begin
                            bc_cnt_d = bc_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d    = SEARCH;
                        bc_cnt_d   = 4'd0;
                        wait_cnt_d = 8'd0;
                    end
                end
                ACTIVE: begin
                    if (is_comma) begin
                        los_cnt_d = 8'd0;
                    end else if (los_cnt_q == LOS_LAST) begin
                        // The byte that declares loss of sync is discarded.
                        state_d    = SEARCH;
                        los_cnt_d  = 8'd0;
                        wait_cnt_d = 8'd0;
                        bc_cnt_d   = 4'd0;
                        lol_inc    = 1'b1;
                    end else begin
                        data_d    = sp_in;
                        valid_d   = 1'b1;
                        los_cnt_d = los_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    bc_cnt_d   = 4'd0;
                    wait_cnt_d = 8'd0;
                    los_cnt_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_4f or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= SEARCH;
            bc_cnt_q   <= 4'd0;
            wait_cnt_q <= 8'd0;
            los_cnt_q  <= 8'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            slip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_cnt_q   <= bc_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            los_cnt_q  <= los_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            slip_q     <= slip_d;
        end
    end

`ifdef SYNC_LOL_CNT_EN
    logic [7:0] lol_q, lol_d;

    always_comb begin
        lol_d = lol_q;
        if (lol_inc && (lol_q != 8'hFF)) begin
            lol_d = lol_q + 8'd1;
        end
    end

    always_ff @(posedge clk_4f or negedge rst_L) begin
        if (!rst_L) begin
            lol_q <= 8'd0;
        end else begin
            lol_q <= lol_d;
        end
    end

    assign lol_cnt = lol_q;
`else
    logic unused_lol_inc;
    assign unused_lol_inc = lol_inc;
    assign lol_cnt        = 8'h00;
`endif

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign bit_slip   = slip_q;
    assign active     = (state_q == ACTIVE);
    assign sync_state = state_q;

endmodule

// File: doc/phy_rx_sync_ctrl.md
# phy_rx_sync_ctrl

Receive-side link synchronization controller for the PHY RX path. It sits directly after the serial-to-parallel deserializer in the `clk_4f` domain and consumes one byte per cycle. It acquires lock by counting consecutive `8'hBC` idle/comma bytes. Once locked, it forwards non-idle bytes as valid data. It requests bit slips from the deserializer while no comma is found, and drops lock when commas stop arriving.

## Interface
- `LOCK_COUNT`, default 4: number of consecutive `8'hBC` bytes required to enter ACTIVE (legal range 1–15).
- `SLIP_WAIT`, default 16: number of consecutive non-BC cycles in SEARCH before a `bit_slip` pulse (legal range 2–255).
- `LOS_LIMIT`, default 64: number of consecutive non-BC bytes in ACTIVE that declares loss of sync (legal range 2–255).
- `clk_4f`, input, 1: byte clock; all state updates on the rising edge.
- `rst_L`, input, 1: asynchronous, active-low reset.
- `sync_en`, input, 1: enables acquisition; low forces SEARCH.
- `sp_in`, input, 8: byte from the deserializer, valid every cycle.
- `data_out`, output, 8: forwarded data byte (registered).
- `valid_out`, output, 1: `data_out` holds a data byte this cycle (registered).
- `active`, output, 1: link locked (decoded from state == ACTIVE).
- `bit_slip`, output, 1: one-cycle request to shift deserializer alignment by one bit (registered).
- `sync_state`, output, 2: SEARCH=0, CHECK=1, ACTIVE=2; encoding 3 is unused.
- `lol_cnt`, output, 8: saturating loss-of-lock count (see Configuration).

## Operation
- **Reset (`rst_L` low):** state=SEARCH; all counters=0; `data_out`=0; `valid_out`=0; `bit_slip`=0; `lol_cnt`=0; `active`=0.
- **`sync_en` low:** next state=SEARCH; counters cleared; `valid_out`=0; `bit_slip`=0. `sync_en` low takes priority over every other event.
- **SEARCH:**
  - `sp_in`==BC: go to CHECK with `bc_cnt`=1. If LOCK_COUNT==1, go straight to ACTIVE. Clear `wait_cnt`.
  - Otherwise: increment `wait_cnt`. When `wait_cnt`==SLIP_WAIT-1, pulse `bit_slip`=1 for one cycle and clear `wait_cnt`.
- **CHECK:**
  - `sp_in`==BC: increment `bc_cnt`. When the count reaches LOCK_COUNT, go to ACTIVE and clear `los_cnt`.
  - Non-BC byte: return to SEARCH with `bc_cnt`=0 and `wait_cnt`=0.
- **ACTIVE:**
  - Non-BC byte: `data_out`<=`sp_in`, `valid_out`<=1, `los_cnt` increments.
  - BC byte: `valid_out`<=0, `data_out` holds its value, `los_cnt`<=0.
  - When a non-BC byte arrives with `los_cnt`==LOS_LIMIT-1: go to SEARCH, `valid_out`<=0 (that byte is discarded), and `lol_cnt` increments (saturates at 255).
- `valid_out` is never 1 outside ACTIVE. `data_out` is not cleared on lock loss.
- `bc_cnt`, `wait_cnt` and `los_cnt` are wide enough for their parameter maxima and never wrap.

## Timing
- Latency from `sp_in` to `data_out`/`valid_out` is 1 `clk_4f` cycle.
- The byte completing LOCK_COUNT commas sets state=ACTIVE at that edge, so `active`=1 in the next cycle. The first data byte after that is valid.
- Loss of lock: `active` falls at the edge that samples the LOS_LIMIT-th consecutive non-BC byte.
- Slip spacing: in a steady non-BC stream in SEARCH, `bit_slip` pulses every SLIP_WAIT cycles; the first pulse comes SLIP_WAIT cycles after entering SEARCH.
- A BC byte arriving in the cycle where a slip would fire suppresses that slip.
- `rst_L` assertion mid-frame immediately forces reset values on all outputs, including `bit_slip`.

## Configuration
- `SYNC_LOL_CNT_EN` defined: the loss-of-lock counter is built, and `lol_cnt` reports lock losses saturating at 255.
- `SYNC_LOL_CNT_EN` undefined: no counter is built and `lol_cnt` is tied to `8'h00`. All other behaviour is identical.

## Test plan
- **Lock acquisition:** reset, `sync_en`=1, drive BC×4 then `8'h11`, `8'h22`. Required: `active`=1 the cycle after the 4th BC; `valid_out`=1 with `data_out`=`8'h11` then `8'h22`, one cycle after each input.
- **Broken acquisition:** drive BC×3, then `8'h55`, then BC×4. Required: state returns to SEARCH after `8'h55`; lock comes only after the later 4 BCs; no `valid_out` for `8'h55`.
- **Slip generation:** drive `8'h00` continuously in SEARCH with SLIP_WAIT=16. Required: single-cycle `bit_slip` pulses at cycles 16, 32, 48; a BC at cycle 16 suppresses the pulse and moves the state to CHECK.
- **Loss of sync:** lock, then drive 64 non-BC bytes with LOS_LIMIT=64. Required: 63 valid bytes; the 64th is dropped; `active`=0; `lol_cnt`=1 (0 without `SYNC_LOL_CNT_EN`). An interleaved BC resets the count so lock is kept.
- **Reset/enable abort:** lock and stream data, then pull `rst_L` low for 1 cycle mid-stream. Required: all outputs go to reset values immediately. Repeat with `sync_en`=0: SEARCH on the next edge, `valid_out`=0.
- **Idle in ACTIVE:** after lock, drive BC,`8'hA0`,BC. Required: `valid_out` sequence 0,1,0 with `data_out`=`8'hA0` held through the trailing BC.
